// File: rtl/led_row_arbiter.sv
// Round-robin owner of the two 8-bit LED rows; each grant dwells HOLD_TICKS tick strobes.
// Optional LED_LIVE_EN: the shown pattern follows the owner's pat slice every cycle during SHOW.
module led_row_arbiter #(
    parameter int          NREQ         = 4,
    parameter int          HOLD_TICKS   = 8,
    parameter logic [15:0] IDLE_PATTERN = 16'h0000
) (
    input  logic                 sys_clk,
    input  logic                 reset,
    input  logic                 tick,
    input  logic [NREQ-1:0]      req,
    input  logic [16*NREQ-1:0]   pat,
    output logic [NREQ-1:0]      grant,
    output logic [NREQ-1:0]      done,
    output logic                 busy,
    output logic [7:0]           led_1,
    output logic [7:0]           led_2
);

    localparam int             IW       = (NREQ > 1) ? $clog2(NREQ) : 1;
    localparam int             CW       = $clog2(HOLD_TICKS + 1);
    localparam logic [IW-1:0]  PTR_INIT = IW'(NREQ - 1);
    localparam logic [CW-1:0]  CNT_LAST = CW'(HOLD_TICKS - 1);

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_SHOW,
        ST_RELEASE
    } state_t;

    state_t          state_reg, state_next;
    logic [IW-1:0]   ptr_reg, ptr_next;
    logic [IW-1:0]   owner_reg, owner_next;
    logic [CW-1:0]   cnt_reg, cnt_next;
    logic [NREQ-1:0] grant_reg, grant_next;
    logic [NREQ-1:0] done_reg, done_next;
    logic            busy_reg, busy_next;
    logic [15:0]     show_reg, show_next;

    logic [15:0]     pat_arr [NREQ];
    logic            pick_valid;
    logic [IW-1:0]   pick_idx;

    for (genvar gi = 0; gi < NREQ; gi++) begin : g_pat
        assign pat_arr[gi] = pat[16*gi +: 16];
    end

    // Scan from farthest to nearest so the nearest requester after ptr wins.
    always_comb begin
        int            idx;
        logic [IW-1:0] cand;
        idx        = 0;
        cand       = '0;
        pick_valid = 1'b0;
        pick_idx   = '0;
        for (int k = NREQ; k >= 1; k--) begin
            idx = int'(ptr_reg) + k;
            if (idx >= NREQ) idx = idx - NREQ;
            cand = IW'(idx);
            if (req[cand]) begin
                pick_valid = 1'b1;
                pick_idx   = cand;
            end
        end
    end

    always_comb begin
        state_next = state_reg;
        ptr_next   = ptr_reg;
        owner_next = owner_reg;
        cnt_next   = cnt_reg;
        grant_next = grant_reg;
        done_next  = '0;
        show_next  = show_reg;
        case (state_reg)
            ST_IDLE: begin
                if (pick_valid) begin
                    grant_next           = '0;
                    grant_next[pick_idx] = 1'b1;
                    owner_next           = pick_idx;
                    show_next            = pat_arr[pick_idx];
                    cnt_next             = '0;
                    state_next           = ST_SHOW;
                end
            end
            ST_SHOW: begin
                // Owner dropping req wins over a coincident final tick: no done pulse.
                if (!req[owner_reg] || (tick && cnt_reg == CNT_LAST)) begin
                    if (req[owner_reg]) done_next = grant_reg;
                    grant_next = '0;
                    show_next  = IDLE_PATTERN;
                    ptr_next   = owner_reg;
                    state_next = ST_RELEASE;
                end else begin
                    if (tick) cnt_next = cnt_reg + CW'(1);
`ifdef LED_LIVE_EN
                    show_next = pat_arr[owner_reg];
`else
                    show_next = show_reg;
`endif
                end
            end
            ST_RELEASE: state_next = ST_IDLE;
            default:    state_next = ST_IDLE;
        endcase
        busy_next = (state_next != ST_IDLE);
    end

    always_ff @(posedge sys_clk or negedge reset) begin
        if (!reset) begin
            state_reg <= ST_IDLE;
            ptr_reg   <= PTR_INIT;
            owner_reg <= '0;
            cnt_reg   <= '0;
            grant_reg <= '0;
            done_reg  <= '0;
            busy_reg  <= 1'b0;
            show_reg  <= IDLE_PATTERN;
        end else begin
            state_reg <= state_next;
            ptr_reg   <= ptr_next;
            owner_reg <= owner_next;
            cnt_reg   <= cnt_next;
            grant_reg <= grant_next;
            done_reg  <= done_next;
            busy_reg  <= busy_next;
            show_reg  <= show_next;
        end
    end

    assign grant = grant_reg;
    assign done  = done_reg;
    assign busy  = busy_reg;
    assign led_1 = show_reg[15:8];
    assign led_2 = show_reg[7:0];

endmodule

// File: tb/tb_led_row_arbiter.sv
// Directed bench for led_row_arbiter: NREQ=4, HOLD_TICKS=8, IDLE_PATTERN=0.
module tb_led_row_arbiter;

    logic        sys_clk = 1'b0;
    logic        reset;
    logic        tick;
    logic [3:0]  req;
    logic [63:0] pat;
    logic [3:0]  grant;
    logic [3:0]  done;
    logic        busy;
    logic [7:0]  led_1;
    logic [7:0]  led_2;

    int n_checks = 0;
    int n_fail   = 0;

    logic [15:0] rr_pat [4] = '{16'hA55A, 16'h2211, 16'h3322, 16'h4433};

`ifdef LED_LIVE_EN
    localparam logic [15:0] MID_EXP = 16'hFF00;
`else
    localparam logic [15:0] MID_EXP = 16'h00FF;
`endif

    led_row_arbiter #(
        .NREQ(4),
        .HOLD_TICKS(8),
        .IDLE_PATTERN(16'h0000)
    ) dut (
        .sys_clk(sys_clk),
        .reset(reset),
        .tick(tick),
        .req(req),
        .pat(pat),
        .grant(grant),
        .done(done),
        .busy(busy),
        .led_1(led_1),
        .led_2(led_2)
    );

    always #5 sys_clk = ~sys_clk;

    task automatic step();
        @(posedge sys_clk);
        #1;
    endtask

    task automatic do_reset();
        reset = 1'b0;
        tick  = 1'b0;
        req   = '0;
        repeat (2) step();
        reset = 1'b1;
        step();
    endtask

    task automatic pulse_ticks(input int count, input int gap);
        for (int t = 0; t < count; t++) begin
            repeat (gap) step();
            tick = 1'b1;
            step();
            tick = 1'b0;
        end
    endtask

    task automatic test_reset();
        reset = 1'b0;
        tick  = 1'b0;
        req   = '0;
        pat   = {rr_pat[3], rr_pat[2], rr_pat[1], rr_pat[0]};
        #2;
        n_checks++;
        if (grant !== 4'b0000 || done !== 4'b0000 || busy !== 1'b0) begin
            $display("FAIL reset_ctrl: grant=%b done=%b busy=%b want 0000 0000 0", grant, done, busy);
            n_fail++;
        end
        n_checks++;
        if ({led_1, led_2} !== 16'h0000) begin
            $display("FAIL reset_leds: got %h want 0000", {led_1, led_2});
            n_fail++;
        end
        repeat (2) step();
        reset = 1'b1;
        step();
        n_checks++;
        if (grant !== 4'b0000 || busy !== 1'b0) begin
            $display("FAIL reset_idle: grant=%b busy=%b want 0000 0", grant, busy);
            n_fail++;
        end
        $display("test_reset done");
    endtask

    task automatic test_single();
        req = 4'b0001;
        step();
        n_checks++;
        if (grant !== 4'b0001 || busy !== 1'b1) begin
            $display("FAIL single_grant: grant=%b busy=%b want 0001 1", grant, busy);
            n_fail++;
        end
        n_checks++;
        if (led_1 !== 8'hA5 || led_2 !== 8'h5A) begin
            $display("FAIL single_leds: got %h/%h want a5/5a", led_1, led_2);
            n_fail++;
        end
        pulse_ticks(7, 3);
        n_checks++;
        if (grant !== 4'b0001 || done !== 4'b0000) begin
            $display("FAIL single_7ticks: grant=%b done=%b want 0001 0000", grant, done);
            n_fail++;
        end
        pulse_ticks(1, 3);
        n_checks++;
        if (grant !== 4'b0000 || done !== 4'b0001 || {led_1, led_2} !== 16'h0000) begin
            $display("FAIL single_release: grant=%b done=%b leds=%h want 0000 0001 0000",
                     grant, done, {led_1, led_2});
            n_fail++;
        end
        req = '0;
        step();
        n_checks++;
        if (done !== 4'b0000 || busy !== 1'b0) begin
            $display("FAIL single_idle: done=%b busy=%b want 0000 0", done, busy);
            n_fail++;
        end
        $display("test_single done");
    endtask

    task automatic test_round_robin();
        int          order [5] = '{0, 1, 2, 3, 0};
        logic [3:0]  exp_g;
        do_reset();
        req = 4'b1111;
        step();
        for (int i = 0; i < 5; i++) begin
            exp_g = 4'b0001 << order[i];
            n_checks++;
            if (grant !== exp_g || {led_1, led_2} !== rr_pat[order[i]]) begin
                $display("FAIL rr_grant%0d: grant=%b leds=%h want %b %h",
                         i, grant, {led_1, led_2}, exp_g, rr_pat[order[i]]);
                n_fail++;
            end
            pulse_ticks(7, 1);
            n_checks++;
            if (grant !== exp_g) begin
                $display("FAIL rr_dwell%0d: grant=%b want %b", i, grant, exp_g);
                n_fail++;
            end
            pulse_ticks(1, 1);
            n_checks++;
            if (grant !== 4'b0000 || done !== exp_g) begin
                $display("FAIL rr_done%0d: grant=%b done=%b want 0000 %b", i, grant, done, exp_g);
                n_fail++;
            end
            if (i < 4) begin
                step();
                n_checks++;
                if (grant !== 4'b0000) begin
                    $display("FAIL rr_gap%0d: grant=%b want 0000", i, grant);
                    n_fail++;
                end
                step();
            end
        end
        req = '0;
        repeat (2) step();
        $display("test_round_robin done");
    endtask

    task automatic test_abort();
        do_reset();
        req = 4'b0100;
        step();
        n_checks++;
        if (grant !== 4'b0100) begin
            $display("FAIL abort_grant: grant=%b want 0100", grant);
            n_fail++;
        end
        pulse_ticks(3, 1);
        req = 4'b1000;
        step();
        n_checks++;
        if (grant !== 4'b0000 || done !== 4'b0000) begin
            $display("FAIL abort_drop: grant=%b done=%b want 0000 0000", grant, done);
            n_fail++;
        end
        step();
        n_checks++;
        if (done !== 4'b0000) begin
            $display("FAIL abort_nodone: done=%b want 0000", done);
            n_fail++;
        end
        step();
        n_checks++;
        if (grant !== 4'b1000) begin
            $display("FAIL abort_next: grant=%b want 1000", grant);
            n_fail++;
        end
        req = 4'b0001;
        repeat (3) step();
        n_checks++;
        if (grant !== 4'b0001) begin
            $display("FAIL abort_wrap: grant=%b want 0001", grant);
            n_fail++;
        end
        req = '0;
        repeat (3) step();
        $display("test_abort done");
    endtask

    task automatic test_coincident();
        do_reset();
        req = 4'b0001;
        step();
        pulse_ticks(7, 1);
        step();
        tick = 1'b1;
        req  = 4'b0000;
        step();
        tick = 1'b0;
        n_checks++;
        if (grant !== 4'b0000 || done !== 4'b0000) begin
            $display("FAIL coinc_release: grant=%b done=%b want 0000 0000", grant, done);
            n_fail++;
        end
        step();
        n_checks++;
        if (done !== 4'b0000) begin
            $display("FAIL coinc_nodone: done=%b want 0000", done);
            n_fail++;
        end
        $display("test_coincident done");
    endtask

    task automatic test_pattern_hold();
        do_reset();
        pat[15:0] = 16'h00FF;
        req = 4'b0001;
        step();
        n_checks++;
        if ({led_1, led_2} !== 16'h00FF) begin
            $display("FAIL pat_initial: got %h want 00ff", {led_1, led_2});
            n_fail++;
        end
        pulse_ticks(2, 1);
        pat[15:0] = 16'hFF00;
        step();
        n_checks++;
        if ({led_1, led_2} !== MID_EXP) begin
            $display("FAIL pat_change: got %h want %h", {led_1, led_2}, MID_EXP);
            n_fail++;
        end
        step();
        n_checks++;
        if ({led_1, led_2} !== MID_EXP) begin
            $display("FAIL pat_steady: got %h want %h", {led_1, led_2}, MID_EXP);
            n_fail++;
        end
        req = '0;
        step();
        n_checks++;
        if ({led_1, led_2} !== 16'h0000) begin
            $display("FAIL pat_release: got %h want 0000", {led_1, led_2});
            n_fail++;
        end
        pat[15:0] = rr_pat[0];
        repeat (2) step();
        $display("test_pattern_hold done");
    endtask

    task automatic test_reset_mid();
        do_reset();
        req = 4'b0100;
        step();
        pulse_ticks(2, 1);
        #2;
        reset = 1'b0;
        #1;
        n_checks++;
        if (grant !== 4'b0000 || done !== 4'b0000 || busy !== 1'b0 || {led_1, led_2} !== 16'h0000) begin
            $display("FAIL rstmid_outputs: grant=%b done=%b busy=%b leds=%h want 0000 0000 0 0000",
                     grant, done, busy, {led_1, led_2});
            n_fail++;
        end
        step();
        reset = 1'b1;
        req   = 4'b1010;
        step();
        n_checks++;
        if (grant !== 4'b0010) begin
            $display("FAIL rstmid_regrant: grant=%b want 0010", grant);
            n_fail++;
        end
        req = '0;
        repeat (3) step();
        $display("test_reset_mid done");
    endtask

    initial begin
        test_reset();
        test_single();
        test_round_robin();
        test_abort();
        test_coincident();
        test_pattern_hold();
        test_reset_mid();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/led_row_arbiter.md
# led_row_arbiter

Shares the two 8-bit LED rows of the CommModem board between up to NREQ requesters (self-test, link status, counter demo, and similar). It grants the rows round-robin. The granted requester's 16-bit pattern is shown for a fixed number of divider ticks, then the rows are released to the next requester. It runs entirely in the sys_clk domain and consumes a one-cycle tick strobe from the clock generator instead of a derived clock.

## Interface
- NREQ, 4, number of requesters (2..8)
- HOLD_TICKS, 8, dwell per grant in tick strobes (>=1)
- IDLE_PATTERN, 16'h0000, LED value when no requester owns the rows
- sys_clk  in  1  system clock, all logic on rising edge
- reset  in  1  asynchronous, active-low reset
- tick  in  1  one-cycle dwell strobe, sys_clk domain
- req  in  NREQ  per-requester request level
- pat  in  16*NREQ  flat patterns; requester i uses pat[16*i+15:16*i]
- grant  out  NREQ  one-hot owner, registered
- done  out  NREQ  one-cycle pulse on normal completion of owner's dwell
- busy  out  1  high whenever state is not IDLE
- led_1  out  8  upper row = show[15:8]
- led_2  out  8  lower row = show[7:0]

## Operation
- State machine: IDLE, SHOW, RELEASE.
- Reset state:
  - state = IDLE.
  - grant = 0, done = 0, busy = 0.
  - show = IDLE_PATTERN.
  - dwell counter = 0.
  - ptr = NREQ-1, so requester 0 wins first.
- IDLE:
  - If any req bit is high, pick the first set bit searching ptr+1, ptr+2, … and wrapping modulo NREQ.
  - At the next edge:
    - Set grant to that one-hot bit.
    - Load show from that requester's pat slice.
    - Clear the counter.
    - Enter SHOW.
  - tick is ignored in IDLE.
- SHOW:
  - Each tick increments the counter.
  - If tick arrives with counter == HOLD_TICKS-1, go to RELEASE and mark the grant as completed.
  - If the owner's req deasserts, go to RELEASE at the next edge and mark it aborted. This takes priority over a coincident final tick.
  - Other requesters' req changes have no effect.
- RELEASE (exactly one cycle):
  - grant = 0 and show = IDLE_PATTERN.
  - done[owner] pulses only if completed.
  - ptr = owner index.
  - Next state is IDLE.
- Fairness: an owner that still requests after release waits behind every other requester that is asserting req.
- Counter width is $clog2(HOLD_TICKS+1); it never wraps because it clears at grant.
- Reset mid-operation:
  - Immediate return to reset values.
  - No done pulse.
  - ptr returns to NREQ-1.

## Timing
- Grant latency:
  - req sampled high at edge N gives grant and LEDs valid after edge N.
  - Earliest is one cycle after req rises, when the block is idle.
- Dwell:
  - The grant edge's own cycle cannot count a tick; counting starts the cycle after entering SHOW.
  - Completion occurs on the edge sampling the HOLD_TICKS-th tick.
  - grant drops and done pulses after that edge.
- Gap between consecutive grants is two cycles minimum: RELEASE plus the IDLE arbitration cycle.
- Abort: grant drops at the edge after req falls is sampled low.
- All outputs are registered; no combinational path from inputs to outputs.

## Configuration
- LED_LIVE_EN defined:
  - During SHOW, show reloads from the owner's pat slice every cycle.
  - Pattern changes appear on the LEDs one cycle later.
- LED_LIVE_EN undefined:
  - show is latched at the grant edge and held for the whole dwell.
  - pat changes during SHOW are ignored.

## Test plan
- Reset, then req=4'b0001, pat0=16'hA55A, HOLD_TICKS=8, tick every 4 cycles:
  - grant=0001 one cycle after req.
  - led_1=8'hA5, led_2=8'h5A.
  - done[0] pulses after the 8th tick.
  - LEDs return to 16'h0000.
- req=4'b1111 held constant:
  - Grant order is 0,1,2,3,0.
  - Every grant is separated by a two-cycle gap.
  - Each grant has exactly 8 ticks of dwell.
- Owner 2 drops req after 3 ticks:
  - grant clears next edge, no done pulse.
  - The next grant goes to 3 if it is requesting, otherwise it wraps.
- Coincident owner-req drop and final tick:
  - Treated as an abort; done stays 0.
- Change pat0 from 16'h00FF to 16'hFF00 mid-dwell:
  - With LED_LIVE_EN, LEDs show FF/00 one cycle later.
  - Without it, LEDs stay 00/FF until release.
- Assert reset during SHOW:
  - All outputs are immediately 0 / IDLE_PATTERN.
  - The next arbitration with req=4'b1010 grants requester 1.
